// File: rtl/scalar_issue_if.sv
`default_nettype none
// scalar_issue_if: dispatch, status-table, writeback and issue-port signals of the scalar issue controller.
interface scalar_issue_if #(
  parameter int NFU  = 3,
  parameter int TAGW = 2
);
  localparam int IW = $clog2(NFU);

  logic                 disp_en;
  logic [IW-1:0]        disp_fu;
  logic [TAGW-1:0]      disp_t1;
  logic [TAGW-1:0]      disp_t2;
  logic [NFU*TAGW-1:0]  fust_t1;
  logic [NFU*TAGW-1:0]  fust_t2;
  logic [NFU-1:0]       fust_spec;
  logic                 flush;
  logic                 wb_valid;
  logic [TAGW-1:0]      wb_tag;
  logic                 iss_ready;
  logic [NFU-1:0]       fu_done;
  logic                 iss_valid;
  logic [IW-1:0]        iss_fu;
  logic [NFU-1:0]       busy_next;
  logic [NFU*TAGW-1:0]  t1_next;
  logic [NFU*TAGW-1:0]  t2_next;

  modport master (
    output disp_en, disp_fu, disp_t1, disp_t2, fust_t1, fust_t2, fust_spec,
           flush, wb_valid, wb_tag, iss_ready, fu_done,
    input  iss_valid, iss_fu, busy_next, t1_next, t2_next
  );

  modport slave (
    input  disp_en, disp_fu, disp_t1, disp_t2, fust_t1, fust_t2, fust_spec,
           flush, wb_valid, wb_tag, iss_ready, fu_done,
    output iss_valid, iss_fu, busy_next, t1_next, t2_next
  );
endinterface
`default_nettype wire

// File: rtl/scalar_issue.sv
`default_nettype none
// scalar_issue: per-FU IDLE/WAIT/ISSUE/EXEC tracking, round-robin issue pick, next status-table values.
// Rev 1.0 -- optional macro ISSUE_WB_BYPASS_EN: writeback tag match wakes a row in the same cycle.
module scalar_issue #(
  parameter int NFU  = 3,
  parameter int TAGW = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  scalar_issue_if.slave bus
);
  localparam int              IW      = $clog2(NFU);
  localparam logic [IW:0]     NFU_C   = (IW+1)'(NFU);
  localparam logic [IW-1:0]   LAST_FU = IW'(NFU - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    EXEC  = 2'd3
  } state_t;

  state_t              state    [NFU];
  state_t              state_nx [NFU];
  logic [IW-1:0]       rr;
  logic                offer_valid;
  logic [IW-1:0]       offer_fu;

  logic                offer_killed;
  logic                port_free;
  logic [NFU-1:0]      kill;
  logic [NFU-1:0]      disp_acc;
  logic [NFU-1:0]      elig;
  logic [NFU-1:0]      busy_nx;
  logic                sel_valid;
  logic [IW-1:0]       sel_fu;
  logic [IW:0]         idx;
  logic [NFU*TAGW-1:0] t1_nx;
  logic [NFU*TAGW-1:0] t2_nx;

  function automatic logic wb_hit(input logic [TAGW-1:0] tag, input logic wvalid,
                                  input logic [TAGW-1:0] wtag);
    return wvalid && (wtag != '0) && (tag == wtag);
  endfunction

  function automatic logic [TAGW-1:0] next_tag(input logic keep, input logic load,
                                               input logic [TAGW-1:0] dtag,
                                               input logic [TAGW-1:0] ftag,
                                               input logic wvalid,
                                               input logic [TAGW-1:0] wtag);
    logic [TAGW-1:0] t;
    t = load ? dtag : ftag;
    if (!keep || wb_hit(t, wvalid, wtag)) t = '0;
    return t;
  endfunction

  // A flushed offer frees nothing this cycle: the port only reopens once iss_valid has dropped.
  assign offer_killed = bus.flush && bus.fust_spec[offer_fu];
  assign port_free    = !offer_valid || (bus.iss_ready && !offer_killed);

  for (genvar g = 0; g < NFU; g++) begin : g_row
    logic [TAGW-1:0] ft1;
    logic [TAGW-1:0] ft2;
    logic [TAGW-1:0] e1;
    logic [TAGW-1:0] e2;

    assign ft1 = bus.fust_t1[g*TAGW +: TAGW];
    assign ft2 = bus.fust_t2[g*TAGW +: TAGW];
`ifdef ISSUE_WB_BYPASS_EN
    assign e1 = wb_hit(ft1, bus.wb_valid, bus.wb_tag) ? '0 : ft1;
    assign e2 = wb_hit(ft2, bus.wb_valid, bus.wb_tag) ? '0 : ft2;
`else
    assign e1 = ft1;
    assign e2 = ft2;
`endif

    assign kill[g]     = bus.flush && bus.fust_spec[g];
    assign disp_acc[g] = bus.disp_en && (bus.disp_fu == IW'(g)) && !kill[g] &&
                         ((state[g] == IDLE) || ((state[g] == EXEC) && bus.fu_done[g]));
    assign elig[g]     = (state[g] == WAIT) && (e1 == '0) && (e2 == '0) &&
                         port_free && !kill[g];
    assign busy_nx[g]  = nRST && (state_nx[g] != IDLE);

    assign t1_nx[g*TAGW +: TAGW] = next_tag(busy_nx[g], disp_acc[g], bus.disp_t1, ft1,
                                            bus.wb_valid, bus.wb_tag);
    assign t2_nx[g*TAGW +: TAGW] = next_tag(busy_nx[g], disp_acc[g], bus.disp_t2, ft2,
                                            bus.wb_valid, bus.wb_tag);
  end

  // Round-robin scan starting at rr, wrapping modulo NFU.
  always_comb begin
    sel_valid = 1'b0;
    sel_fu    = '0;
    idx       = '0;
    for (int k = 0; k < NFU; k++) begin
      idx = {1'b0, rr} + (IW+1)'(k);
      if (idx >= NFU_C) idx = idx - NFU_C;
      if (!sel_valid && elig[idx[IW-1:0]]) begin
        sel_valid = 1'b1;
        sel_fu    = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NFU; i++) begin
      state_nx[i] = state[i];
      if (kill[i]) begin
        state_nx[i] = IDLE;
      end else begin
        case (state[i])
          IDLE:    if (disp_acc[i]) state_nx[i] = WAIT;
          WAIT:    if (sel_valid && (sel_fu == IW'(i))) state_nx[i] = ISSUE;
          ISSUE:   if (bus.iss_ready && offer_valid && (offer_fu == IW'(i))) state_nx[i] = EXEC;
          EXEC:    if (bus.fu_done[i]) state_nx[i] = disp_acc[i] ? WAIT : IDLE;
          default: state_nx[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NFU; i++) state[i] <= IDLE;
      rr          <= '0;
      offer_valid <= 1'b0;
      offer_fu    <= '0;
    end else begin
      for (int i = 0; i < NFU; i++) state[i] <= state_nx[i];
      if (sel_valid) begin
        offer_valid <= 1'b1;
        offer_fu    <= sel_fu;
        rr          <= (sel_fu == LAST_FU) ? '0 : sel_fu + 1'b1;
      end else if (offer_valid && (bus.iss_ready || offer_killed)) begin
        offer_valid <= 1'b0;
      end
    end
  end

  assign bus.iss_valid = offer_valid;
  assign bus.iss_fu    = offer_fu;
  assign bus.busy_next = busy_nx;
  assign bus.t1_next   = t1_nx;
  assign bus.t2_next   = t2_nx;

endmodule
`default_nettype wire

// File: tb/tb_scalar_issue.sv
`default_nettype none
// tb_scalar_issue: directed checks of the scalar issue controller with a registered status-table stand-in.
module tb_scalar_issue;
`ifdef ISSUE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] spec = 3'b000;
  logic [5:0] tab_t1;
  logic [5:0] tab_t2;
  int         checks = 0;
  int         errors = 0;

  scalar_issue_if #(.NFU(3), .TAGW(2)) bus ();

  scalar_issue #(.NFU(3), .TAGW(2)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Status table: registers whatever the controller proposes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tab_t1 <= '0;
      tab_t2 <= '0;
    end else begin
      tab_t1 <= bus.t1_next;
      tab_t2 <= bus.t2_next;
    end
  end
  assign bus.fust_t1   = tab_t1;
  assign bus.fust_t2   = tab_t2;
  assign bus.fust_spec = spec;

  task automatic clear_inputs();
    bus.disp_en   = 1'b0;
    bus.disp_fu   = '0;
    bus.disp_t1   = '0;
    bus.disp_t2   = '0;
    bus.flush     = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_tag    = '0;
    bus.iss_ready = 1'b0;
    bus.fu_done   = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    spec  = 3'b000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    bus.disp_en = 1'b1; bus.disp_fu = 2'd1; bus.disp_t1 = 2'd2; bus.disp_t2 = 2'd1;
    @(posedge clk);
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid got %b exp 0", bus.iss_valid); end
    checks++; if (bus.iss_fu !== 2'd0) begin errors++; $display("FAIL rst_iss_fu got %0d exp 0", bus.iss_fu); end
    checks++; if (bus.busy_next !== 3'b000) begin errors++; $display("FAIL rst_busy got %b exp 000", bus.busy_next); end
    checks++; if (bus.t1_next !== 6'd0) begin errors++; $display("FAIL rst_t1 got %h exp 0", bus.t1_next); end
    checks++; if (bus.t2_next !== 6'd0) begin errors++; $display("FAIL rst_t2 got %h exp 0", bus.t2_next); end
    clear_inputs();
    #3 rst_n = 1'b1;
  endtask

  task automatic test_dispatch_issue();
    next_cycle();
    bus.disp_en = 1'b1; bus.disp_fu = 2'd1; bus.iss_ready = 1'b1;
    #1;
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL disp_busy got %b exp 010", bus.busy_next); end
    next_cycle();
    bus.disp_en = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL disp_latency got %b exp 0", bus.iss_valid); end
    next_cycle(); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL disp_offer_valid got %b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_fu !== 2'd1) begin errors++; $display("FAIL disp_offer_fu got %0d exp 1", bus.iss_fu); end
    next_cycle(); #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL disp_drop got %b exp 0", bus.iss_valid); end
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL disp_exec_busy got %b exp 010", bus.busy_next); end
    next_cycle();
    bus.fu_done = 3'b010;
    #1;
    checks++; if (bus.busy_next !== 3'b000) begin errors++; $display("FAIL disp_done_busy got %b exp 000", bus.busy_next); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_wakeup();
    next_cycle();
    bus.disp_en = 1'b1; bus.disp_fu = 2'd0; bus.disp_t1 = 2'd2; bus.disp_t2 = 2'd0;
    #1;
    checks++; if (bus.t1_next[1:0] !== 2'd2) begin errors++; $display("FAIL wake_t1_load got %0d exp 2", bus.t1_next[1:0]); end
    next_cycle();
    bus.disp_en = 1'b0;
    #1;
    next_cycle();
    bus.wb_valid = 1'b1; bus.wb_tag = 2'd2;
    #1;
    checks++; if (bus.t1_next[1:0] !== 2'd0) begin errors++; $display("FAIL wake_t1_clear got %0d exp 0", bus.t1_next[1:0]); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wake_wb_cycle got %b exp 0", bus.iss_valid); end
    next_cycle();
    bus.wb_valid = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== BYP) begin errors++; $display("FAIL wake_early got %b exp %b", bus.iss_valid, BYP); end
    next_cycle(); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL wake_offer_valid got %b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_fu !== 2'd0) begin errors++; $display("FAIL wake_offer_fu got %0d exp 0", bus.iss_fu); end
    next_cycle();
    bus.iss_ready = 1'b1;
    #1;
    next_cycle();
    bus.iss_ready = 1'b0; bus.fu_done = 3'b001;
    #1;
    checks++; if (bus.busy_next !== 3'b000) begin errors++; $display("FAIL wake_done_busy got %b exp 000", bus.busy_next); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    next_cycle();
    bus.iss_ready = 1'b1;
    bus.disp_en = 1'b1; bus.disp_fu = 2'd0; bus.disp_t1 = 2'd3; bus.disp_t2 = 2'd0;
    #1;
    next_cycle();
    bus.disp_fu = 2'd1; bus.disp_t1 = 2'd0; bus.disp_t2 = 2'd3;
    #1;
    next_cycle();
    bus.disp_fu = 2'd2; bus.disp_t1 = 2'd3; bus.disp_t2 = 2'd3;
    #1;
    next_cycle();
    bus.disp_en = 1'b0; bus.wb_valid = 1'b1; bus.wb_tag = 2'd3;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rr_before_wake got %b exp 0", bus.iss_valid); end
    checks++; if (bus.t2_next[5:4] !== 2'd0) begin errors++; $display("FAIL rr_t2_clear got %0d exp 0", bus.t2_next[5:4]); end
    next_cycle();
    bus.wb_valid = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== BYP) begin errors++; $display("FAIL rr_first_offer got %b exp %b", bus.iss_valid, BYP); end
    if (!BYP) next_cycle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL rr_valid_%0d got %b exp 1", k, bus.iss_valid); end
      checks++; if (bus.iss_fu !== 2'(k)) begin errors++; $display("FAIL rr_order_%0d got %0d exp %0d", k, bus.iss_fu, k); end
      next_cycle();
    end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", bus.iss_valid); end
    bus.iss_ready = 1'b0; bus.fu_done = 3'b111;
    #1;
    checks++; if (bus.busy_next !== 3'b000) begin errors++; $display("FAIL rr_done_busy got %b exp 000", bus.busy_next); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_hold();
    next_cycle();
    bus.disp_en = 1'b1; bus.disp_fu = 2'd2;
    #1;
    next_cycle();
    bus.disp_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d got %b exp 1", k, bus.iss_valid); end
      checks++; if (bus.iss_fu !== 2'd2) begin errors++; $display("FAIL hold_fu_%0d got %0d exp 2", k, bus.iss_fu); end
    end
    next_cycle();
    bus.iss_ready = 1'b1;
    #1;
    checks++; if (bus.iss_fu !== 2'd2) begin errors++; $display("FAIL hold_accept_fu got %0d exp 2", bus.iss_fu); end
    next_cycle();
    bus.iss_ready = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got %b exp 0", bus.iss_valid); end
    checks++; if (bus.busy_next !== 3'b100) begin errors++; $display("FAIL hold_exec_busy got %b exp 100", bus.busy_next); end
    next_cycle();
    bus.fu_done = 3'b100;
    #1;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_flush();
    spec = 3'b101;
    next_cycle();
    bus.iss_ready = 1'b1; bus.disp_en = 1'b1; bus.disp_fu = 2'd0;
    #1;
    next_cycle();
    bus.disp_fu = 2'd2;
    #1;
    next_cycle();
    bus.disp_fu = 2'd1;
    #1;
    checks++; if (bus.iss_fu !== 2'd0) begin errors++; $display("FAIL flush_setup_fu0 got %0d exp 0", bus.iss_fu); end
    next_cycle();
    bus.disp_en = 1'b0; bus.iss_ready = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_fu !== 2'd2) begin errors++; $display("FAIL flush_setup_fu2 got %b/%0d exp 1/2", bus.iss_valid, bus.iss_fu); end
    next_cycle();
    bus.flush = 1'b1; bus.iss_ready = 1'b1;
    #1;
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL flush_busy got %b exp 010", bus.busy_next); end
    checks++; if (bus.t1_next !== 6'd0 || bus.t2_next !== 6'd0) begin errors++; $display("FAIL flush_tags got %h/%h exp 0/0", bus.t1_next, bus.t2_next); end
    next_cycle();
    bus.flush = 1'b0; spec = 3'b000;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", bus.iss_valid); end
    next_cycle(); #1;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL flush_row1_valid got %b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_fu !== 2'd1) begin errors++; $display("FAIL flush_row1_fu got %0d exp 1", bus.iss_fu); end
    next_cycle();
    bus.iss_ready = 1'b0; bus.fu_done = 3'b001;
    #1;
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL flush_late_done got %b exp 010", bus.busy_next); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    clear_inputs();
    bus.fu_done = 3'b010; bus.disp_en = 1'b1; bus.disp_fu = 2'd1; bus.disp_t1 = 2'd2; bus.disp_t2 = 2'd3;
    #1;
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL b2b_busy got %b exp 010", bus.busy_next); end
    checks++; if (bus.t1_next[3:2] !== 2'd2) begin errors++; $display("FAIL b2b_t1 got %0d exp 2", bus.t1_next[3:2]); end
    checks++; if (bus.t2_next[3:2] !== 2'd3) begin errors++; $display("FAIL b2b_t2 got %0d exp 3", bus.t2_next[3:2]); end
    next_cycle();
    bus.fu_done = 3'b000; bus.disp_t1 = 2'd1; bus.disp_t2 = 2'd0;
    #1;
    checks++; if (bus.t1_next[3:2] !== 2'd2) begin errors++; $display("FAIL ign_disp_t1 got %0d exp 2", bus.t1_next[3:2]); end
    checks++; if (bus.t2_next[3:2] !== 2'd3) begin errors++; $display("FAIL ign_disp_t2 got %0d exp 3", bus.t2_next[3:2]); end
    checks++; if (bus.busy_next !== 3'b010) begin errors++; $display("FAIL ign_disp_busy got %b exp 010", bus.busy_next); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL ign_disp_valid got %b exp 0", bus.iss_valid); end
    next_cycle();
    bus.disp_en = 1'b0; bus.wb_valid = 1'b1; bus.wb_tag = 2'd2;
    #1;
    checks++; if (bus.t1_next[3:2] !== 2'd0) begin errors++; $display("FAIL b2b_wb_t1 got %0d exp 0", bus.t1_next[3:2]); end
    checks++; if (bus.t2_next[3:2] !== 2'd3) begin errors++; $display("FAIL b2b_wb_t2_hold got %0d exp 3", bus.t2_next[3:2]); end
    next_cycle();
    bus.wb_tag = 2'd3;
    #1;
    checks++; if (bus.t2_next[3:2] !== 2'd0) begin errors++; $display("FAIL b2b_wb_t2 got %0d exp 0", bus.t2_next[3:2]); end
    next_cycle();
    bus.wb_valid = 1'b0;
    #1;
    next_cycle(); #1;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_fu !== 2'd1) begin errors++; $display("FAIL b2b_offer got %b/%0d exp 1/1", bus.iss_valid, bus.iss_fu); end
  endtask

  task automatic test_mid_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.iss_valid); end
    checks++; if (bus.busy_next !== 3'b000) begin errors++; $display("FAIL midrst_busy got %b exp 000", bus.busy_next); end
    checks++; if (bus.iss_fu !== 2'd0) begin errors++; $display("FAIL midrst_fu got %0d exp 0", bus.iss_fu); end
    clear_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_dispatch_issue();
    test_wakeup();
    test_round_robin();
    test_hold();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/scalar_issue.md
# scalar_issue

Scalar issue controller: the consumer side of the scalar functional-unit status table. It reads the table's busy, source-tag and speculation fields and tracks each scalar FU through wait, issue and execute. It clears source tags on writeback broadcast and picks one ready FU per cycle, round-robin, for the operand-read/issue port. It also computes the next busy/t1/t2 values the status table registers each cycle, closing the dispatch → table → issue → table loop.

## Interface
- NFU, default 3: number of scalar FUs (table rows).
- TAGW, default 2: producer-tag width. Tag 0 = operand ready; tag k (1..NFU) = pending result of FU k-1.
- CLK  in  1: clock.
- nRST  in  1: asynchronous, active-low reset.
- disp_en  in  1: dispatch writes a row this cycle.
- disp_fu  in  $clog2(NFU): target row.
- disp_t1, disp_t2  in  TAGW: producer tags of the dispatched op's sources.
- fust_t1, fust_t2  in  NFU*TAGW: current registered table tags (row i at [i*TAGW +: TAGW]).
- fust_spec  in  NFU: current registered speculation bits.
- flush  in  1: squash speculative rows.
- wb_valid  in  1: writeback broadcast valid.
- wb_tag  in  TAGW: tag being written back.
- iss_ready  in  1: operand-read/issue port accepts.
- fu_done  in  NFU: one-cycle pulse, FU i finished execution.
- iss_valid  out  1: registered; an op is offered on the issue port.
- iss_fu  out  $clog2(NFU): registered; row being offered.
- busy_next  out  NFU: next busy bits for the table.
- t1_next, t2_next  out  NFU*TAGW: next tag fields for the table.

## Operation
- Per-row FSM, states IDLE, WAIT, ISSUE, EXEC:
  - IDLE → WAIT on disp_en && disp_fu==i.
  - WAIT → ISSUE when the row is selected by the arbiter.
  - ISSUE → EXEC on iss_ready while iss_fu==i.
  - EXEC → IDLE on fu_done[i].
  - EXEC with fu_done[i] and a dispatch to row i in the same cycle → WAIT (back-to-back reuse).
- Dispatch to a row that is not IDLE (excluding the EXEC+fu_done case) is ignored; no state or tag change.
- Eligible row: state WAIT, effective t1==0 and t2==0, and no op currently held in ISSUE.
- Effective tag: the registered fust tag. With ISSUE_WB_BYPASS_EN, a tag equal to a valid nonzero wb_tag counts as 0 in the same cycle.
- Arbiter: round-robin pointer rr. Scan from rr upward, modulo NFU. On each selection, rr ← selected+1 mod NFU.
- busy_next[i] = 1 iff the row's next state ≠ IDLE.
- t1_next/t2_next, in priority order:
  - disp_en to row i (accepted): take disp_t1/disp_t2. A disp tag equal to the same-cycle valid wb_tag is written as 0.
  - otherwise, a tag matching a valid nonzero wb_tag: 0.
  - otherwise: hold the fust value.
  - a row going to IDLE: 0.
- flush: every row with fust_spec=1 goes IDLE and its tags go to 0. flush beats dispatch, selection and fu_done for that row. Non-speculative rows are unaffected.
- A later fu_done for a flushed row is ignored while the row is IDLE.

## Timing
- Reset: all rows IDLE, rr=0, iss_valid=0, iss_fu=0. busy_next=0 and t1_next/t2_next=0 while nRST is low.
- Selection in cycle N → iss_valid=1 and iss_fu valid from cycle N+1.
- iss_valid holds, with iss_fu stable, until the cycle iss_ready=1. It drops in the cycle after acceptance unless a new row is selected in the accept cycle.
- Accept and new selection may overlap: at most one issue per cycle, no bubble.
- Dispatch in cycle N; earliest selection in cycle N+1, when the table shows the tags; earliest iss_valid in N+2.
- Writeback in cycle N:
  - without bypass, a dependent row is eligible at N+1;
  - with ISSUE_WB_BYPASS_EN, it is eligible at N.
- Flush of the row currently offered: iss_valid=0 from the next cycle, and rr is unchanged. Flush takes effect even when iss_ready=1 that cycle; the op counts as not issued.
- Reset asserted mid-operation clears everything immediately. busy_next outputs drop asynchronously.

## Configuration
- ISSUE_WB_BYPASS_EN:
  - Defined: wb_tag compare is applied to fust tags before the eligibility check, saving one cycle of wakeup latency.
  - Undefined: eligibility uses the registered table tags only. wb still clears tags through t1_next/t2_next.

## Test plan
- Reset, then dispatch FU1 with t1=0, t2=0 at cycle 2, iss_ready=1 → iss_valid=1, iss_fu=1 at cycle 4; busy_next[1]=1; fu_done[1] at cycle 7 → busy_next[1]=0.
- Dispatch FU0 t1=2 (waits on FU1); wb_tag=2 at cycle 5:
  - t1_next[0]=0 in cycle 5;
  - without bypass, iss_valid at 7; with ISSUE_WB_BYPASS_EN, iss_valid at 6.
- Rows 0, 1 and 2 all ready at once with iss_ready=1, rr=0 → issue order 0, 1, 2 on consecutive cycles.
- Row 2 offered with iss_ready=0 for 3 cycles → iss_valid and iss_fu=2 held stable; iss_ready=1 → row 2 enters EXEC; iss_valid=0 next cycle.
- Rows 0 and 2 spec=1 (row 0 in EXEC, row 2 in ISSUE), row 1 non-spec WAIT, flush=1:
  - rows 0 and 2 IDLE with tags 0; iss_valid=0 next cycle;
  - row 1 still issues;
  - a later fu_done[0] is ignored.
- Row 1 in EXEC, fu_done[1] and disp_en to FU1 in the same cycle → row 1 in WAIT, busy_next[1] stays 1, new tags loaded.
